// File: rtl/l2_bus_request_unit.sv
// l2_bus_request_unit: arbitrates one line-granular L2 request onto the system bus, handles snoop/HITM retry and data completion.
// Optional build macro L2_BUS_STATS_EN adds saturating transaction and retry counters.
module l2_bus_request_unit #(
   parameter int ADDR_W     = 32,
   parameter int OFFSET_W   = 6,
   parameter int SNOOP_WAIT = 3,
   parameter int MAX_RETRY  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   output logic [1:0]        rsp_snoop,
   output logic              rsp_error,
   output logic              bus_valid,
   output logic [1:0]        bus_op,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_grant,
   input  logic              bus_snoop_valid,
   input  logic [1:0]        bus_snoop,
   input  logic              bus_data_done
`ifdef L2_BUS_STATS_EN
   ,
   output logic [31:0]       stat_txn_cnt,
   output logic [31:0]       stat_retry_cnt
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_SNOOP = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_RFO   = 2'd1;
   localparam logic [1:0] OP_WB    = 2'd2;

   localparam logic [1:0] SN_HIT   = 2'b00;
   localparam logic [1:0] SN_HITM  = 2'b01;
   localparam logic [1:0] SN_NOHIT = 2'b10;

   logic [2:0]        state;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        retry_cnt;
   logic [3:0]        wait_cnt;
   logic [1:0]        result;
   logic              err;
   logic              rsp_valid_q;
   logic [1:0]        rsp_snoop_q;
   logic              rsp_error_q;
   logic [1:0]        snoop_eff;
   logic              retry_evt;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[OFFSET_W-1:0];

   assign req_ready = (state == S_IDLE);
   assign bus_valid = (state == S_ARB);
   assign bus_op    = op_q;
   assign bus_addr  = addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_snoop = rsp_snoop_q;
   assign rsp_error = rsp_error_q;

   // The reserved snoop code is folded into NOHIT before any decision.
   assign snoop_eff = (bus_snoop == 2'b11) ? SN_NOHIT : bus_snoop;
   assign retry_evt = (state == S_SNOOP) && bus_snoop_valid && (snoop_eff == SN_HITM)
                      && (retry_cnt != 4'(MAX_RETRY));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= 2'd0;
         addr_q      <= '0;
         retry_cnt   <= 4'd0;
         wait_cnt    <= 4'd0;
         result      <= SN_NOHIT;
         err         <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_snoop_q <= SN_NOHIT;
         rsp_error_q <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  addr_q    <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  retry_cnt <= 4'd0;
                  err       <= 1'b0;
                  state     <= S_ARB;
               end
            end
            S_ARB: begin
               if (bus_grant) begin
                  if (op_q == OP_READ || op_q == OP_RFO) begin
                     wait_cnt <= 4'd0;
                     state    <= S_SNOOP;
                  end else if (op_q == OP_WB) begin
                     result <= SN_NOHIT;
                     state  <= S_DATA;
                  end else begin
                     result <= SN_HIT;
                     state  <= S_RESP;
                  end
               end
            end
            S_SNOOP: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (bus_snoop_valid) begin
                  if (retry_evt) begin
                     retry_cnt <= retry_cnt + 4'd1;
                     state     <= S_ARB;
                  end else if (snoop_eff == SN_HITM) begin
                     result <= SN_HITM;
                     err    <= 1'b1;
                     state  <= S_RESP;
                  end else begin
                     result <= snoop_eff;
                     state  <= S_DATA;
                  end
               end else if (wait_cnt == 4'(SNOOP_WAIT - 1)) begin
                  result <= SN_NOHIT;
                  state  <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus_data_done) state <= S_RESP;
            end
            S_RESP: begin
               rsp_valid_q <= 1'b1;
               rsp_snoop_q <= result;
               rsp_error_q <= err;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef L2_BUS_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_txn_cnt   <= 32'd0;
         stat_retry_cnt <= 32'd0;
      end else begin
         if (rsp_valid_q && stat_txn_cnt != 32'hFFFF_FFFF)
            stat_txn_cnt <= stat_txn_cnt + 32'd1;
         if (retry_evt && stat_retry_cnt != 32'hFFFF_FFFF)
            stat_retry_cnt <= stat_retry_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_bus_request_unit.sv
// Directed scoreboard bench for l2_bus_request_unit (default build, stats disabled).
module tb_l2_bus_request_unit;
   logic        clk = 0;
   logic        rst = 1;
   logic        req_valid = 0;
   logic        req_ready;
   logic [1:0]  req_op = 0;
   logic [31:0] req_addr = 0;
   logic        rsp_valid;
   logic [1:0]  rsp_snoop;
   logic        rsp_error;
   logic        bus_valid;
   logic [1:0]  bus_op;
   logic [31:0] bus_addr;
   logic        bus_grant = 0;
   logic        bus_snoop_valid = 0;
   logic [1:0]  bus_snoop = 0;
   logic        bus_data_done = 1;

   l2_bus_request_unit #(.ADDR_W(32), .OFFSET_W(6), .SNOOP_WAIT(3), .MAX_RETRY(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .rsp_error(rsp_error),
      .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_grant(bus_grant),
      .bus_snoop_valid(bus_snoop_valid), .bus_snoop(bus_snoop), .bus_data_done(bus_data_done));

   always #5 clk = ~clk;

   typedef struct { logic [1:0] snoop; logic err; } exp_t;
   exp_t exp_q[$];
   int   snoop_script[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   grant_cnt = 0;
   logic auto_grant = 1;
   logic grant_prev = 0;
   logic [31:0] last_bus_addr = 0;
   logic [1:0]  last_bus_op = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus-side responder: grants whenever requested, then plays one snoop script entry in the following cycle.
   initial begin
      forever begin
         @(negedge clk);
         bus_snoop_valid = 0;
         if (grant_prev) begin
            int v;
            v = (snoop_script.size() > 0) ? snoop_script.pop_front() : -1;
            if (v >= 0) begin
               bus_snoop_valid = 1;
               bus_snoop = 2'(v);
            end
         end
         if (bus_valid) begin
            last_bus_addr = bus_addr;
            last_bus_op = bus_op;
         end
         grant_prev = bus_valid && auto_grant;
         bus_grant = grant_prev;
         if (grant_prev) grant_cnt++;
      end
   end

   task automatic accept(input logic [1:0] op, input logic [31:0] addr,
                         input logic [1:0] esn, input logic eerr, output int t1);
      exp_t e;
      @(negedge clk);
      req_valid = 1; req_op = op; req_addr = addr;
      e.snoop = esn; e.err = eerr;
      exp_q.push_back(e);
      @(negedge clk);
      t1 = cyc;
      req_valid = 0; req_op = ~op; req_addr = ~addr;
   endtask

   task automatic wait_rsp(input string tag, input int t1, input int exp_lat);
      int n = 0;
      exp_t e;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{2'bxx, 1'bx};
         chk({tag, "_snoop"}, rsp_snoop, e.snoop);
         chk({tag, "_error"}, rsp_error, e.err);
         chk({tag, "_latency"}, cyc - t1 + 1, exp_lat);
         @(negedge clk);
         chk({tag, "_pulse"}, rsp_valid, 0);
      end
   endtask

   initial begin
      int t1, t2, n, bad;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_rsp_snoop", rsp_snoop, 2'b10);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_bus_addr", {bus_op, bus_addr}, 0);

      // READ, immediate grant, NOHIT in first snoop cycle
      grant_cnt = 0; snoop_script.push_back(2);
      accept(2'd0, 32'h1234_5678, 2'b10, 0, t1);
      wait_rsp("read", t1, 5);
      chk("read_bus_addr", last_bus_addr, 32'h1234_5640);
      chk("read_bus_op", last_bus_op, 0);
      chk("read_grants", grant_cnt, 1);

      // RFO: HITM, HITM, HIT
      grant_cnt = 0; snoop_script = '{1, 1, 0};
      accept(2'd1, 32'hABCD_EF7F, 2'b00, 0, t1);
      wait_rsp("rfo", t1, 9);
      chk("rfo_grants", grant_cnt, 3);
      chk("rfo_bus_addr", last_bus_addr, 32'hABCD_EF40);

      // READ with HITM every attempt: 1 + MAX_RETRY grants, then error
      grant_cnt = 0; snoop_script = '{1, 1, 1, 1, 1};
      accept(2'd0, 32'h0000_1000, 2'b01, 1, t1);
      wait_rsp("hitm_all", t1, 12);
      chk("hitm_all_grants", grant_cnt, 5);
      repeat (3) @(negedge clk);
      chk("hitm_all_hold_err", {rsp_snoop, rsp_error}, {2'b01, 1'b1});

      // READ with no snoop: three SNOOP cycles then DATA, NOHIT
      grant_cnt = 0; snoop_script.delete();
      accept(2'd0, 32'h8000_0040, 2'b10, 0, t1);
      wait_rsp("snoop_timeout", t1, 7);

      // Reserved snoop code behaves as NOHIT
      snoop_script.push_back(3);
      accept(2'd0, 32'h0000_0080, 2'b10, 0, t1);
      wait_rsp("snoop_rsvd", t1, 5);

      // WRITEBACK then INVALIDATE with req_valid held high
      grant_cnt = 0; snoop_script.delete();
      @(negedge clk);
      req_valid = 1; req_op = 2'd2; req_addr = 32'h0000_2345;
      exp_q.push_back('{2'b10, 1'b0});
      @(negedge clk);
      t1 = cyc;
      req_op = 2'd3; req_addr = 32'h0000_5FFF;
      exp_q.push_back('{2'b00, 1'b0});
      n = 0; bad = 0;
      while (!rsp_valid && n < 100) begin
         if (req_ready) bad++;
         @(negedge clk);
         n++;
      end
      chk("b2b_ready_low_while_busy", bad, 0);
      chk("b2b_wb_bus_addr", last_bus_addr, 32'h0000_2340);
      wait_rsp("b2b_wb", t1, 4);
      t2 = cyc;
      req_valid = 0;
      chk("b2b_inv_bus_valid", bus_valid, 1);
      chk("b2b_inv_bus", {bus_op, bus_addr}, {2'd3, 32'h0000_5FC0});
      wait_rsp("b2b_inv", t2, 3);
      chk("b2b_grants", grant_cnt, 2);

      // Reset while in DATA abandons the transaction
      bus_data_done = 0; snoop_script.push_back(0);
      @(negedge clk);
      req_valid = 1; req_op = 2'd0; req_addr = 32'h0F0F_0F0F;
      @(negedge clk);
      req_valid = 0;
      repeat (2) @(negedge clk);
      chk("rstmid_in_data", {req_ready, bus_valid}, 2'b00);
      rst = 1;
      @(negedge clk);
      chk("rstmid_ready", req_ready, 1);
      chk("rstmid_bus", {bus_valid, bus_op, bus_addr}, 0);
      chk("rstmid_rsp_valid", rsp_valid, 0);
      rst = 0; bus_data_done = 1;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) bad++;
      end
      chk("rstmid_no_rsp", bad, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/l2_bus_request_unit.md
Name: l2_bus_request_unit

Overview:
- Downstream stage of the L2 cache controller.
- Takes one line-granular bus request from the L2 (read miss fill, read-for-ownership, dirty writeback, invalidate) and arbitrates for the shared system bus.
- Collects the snoop result from the other caches, retries on HITM, waits for data completion, then returns the snoop result to the L2 for its MESI update.

Parameters:
- ADDR_W, 32: bus address width.
- OFFSET_W, 6: line offset bits, forced to zero on the bus.
- SNOOP_WAIT, 3: cycles after grant to wait for bus_snoop_valid before defaulting to NOHIT (1..15).
- MAX_RETRY, 4: HITM retries allowed per request before error (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  L2 request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  0=READ, 1=RFO, 2=WRITEBACK, 3=INVALIDATE.
- req_addr  in  ADDR_W  byte address of the line.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_snoop  out  2  00=HIT, 01=HITM, 10=NOHIT; valid with rsp_valid.
- rsp_error  out  1  retry limit exceeded; valid with rsp_valid.
- bus_valid  out  1  bus request asserted.
- bus_op  out  2  same encoding as req_op.
- bus_addr  out  ADDR_W  line-aligned address.
- bus_grant  in  1  arbiter grant.
- bus_snoop_valid  in  1  bus_snoop is valid.
- bus_snoop  in  2  snoop result from the other caches.
- bus_data_done  in  1  data phase complete.

Behaviour:
- Single clock. Synchronous active-high reset. All state is updated on the clk rising edge.
- Reset values:
  - state=IDLE.
  - req_ready=1.
  - rsp_valid, rsp_error, bus_valid = 0.
  - rsp_snoop=NOHIT.
  - bus_op=0, bus_addr=0.
  - Retry and wait counters = 0.
- Reset mid-transaction abandons the transaction immediately. No rsp_valid is produced for it.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - req_op and {req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0} are latched at acceptance.
  - Inputs that change after acceptance are ignored.
- States:
  - IDLE → ARB on acceptance.
  - ARB: bus_valid=1, bus_op and bus_addr driven from the latched values.
    - bus_grant sampled high → bus_valid drops the next cycle.
    - Next state is SNOOP for READ/RFO, DATA for WRITEBACK, RESP for INVALIDATE (INVALIDATE reports HIT).
    - A grant in the same cycle bus_valid first rises is legal.
  - SNOOP: wait counter increments each cycle.
    - First cycle with bus_snoop_valid=1 latches bus_snoop.
    - No valid within SNOOP_WAIT cycles → result=NOHIT.
    - bus_snoop=11 (reserved) is treated as NOHIT.
    - Result HITM and retry<MAX_RETRY → retry++, return to ARB.
    - Result HITM and retry==MAX_RETRY → RESP with rsp_error=1, rsp_snoop=HITM.
    - Result HIT or NOHIT → DATA.
  - DATA: waits indefinitely for bus_data_done=1, then RESP.
    - WRITEBACK reports NOHIT.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
    - rsp_snoop and rsp_error hold their values until the next RESP.
- Response latency:
  - Minimum accept-to-rsp_valid is 3 cycles for INVALIDATE (grant in first ARB cycle).
  - Minimum is 5 cycles for READ (grant immediate, snoop in first cycle, data_done in first DATA cycle).
- The retry counter clears at acceptance. The wait counter clears on each SNOOP entry.
- bus_data_done or bus_snoop_valid outside the DATA and SNOOP states is ignored.

Optional Feature:
- Macro: L2_BUS_STATS_EN.
- When defined:
  - Adds outputs stat_txn_cnt (32) and stat_retry_cnt (32).
  - stat_txn_cnt increments on each rsp_valid.
  - stat_retry_cnt increments on each HITM retry.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- READ addr 32'h1234_5678, grant in cycle 1, bus_snoop=NOHIT in the first SNOOP cycle, data_done immediately → bus_addr=32'h1234_5640; rsp_valid at cycle 5 with rsp_snoop=10, rsp_error=0.
- RFO with snoop HITM twice then HIT → bus_valid reasserts twice; rsp_snoop=00; stat_retry_cnt=2 when L2_BUS_STATS_EN is defined.
- READ with HITM on every attempt, MAX_RETRY=4 → 5 grants total; rsp_valid with rsp_error=1, rsp_snoop=01.
- READ with bus_snoop_valid never asserted, SNOOP_WAIT=3 → after 3 SNOOP cycles the unit enters DATA; rsp_snoop=NOHIT.
- WRITEBACK then INVALIDATE back-to-back, req_valid held high → the second request is accepted only after the first rsp_valid; INVALIDATE has no DATA phase and returns rsp_snoop=00.
- rst asserted while in DATA → the next cycle shows state IDLE, req_ready=1, bus_valid=0, and no rsp_valid.
